// File: rtl/mem_access_unit.sv
// Data-memory initiator: byte/half/word loads and stores on a word-wide memory.
// Latency: fault 1, load 2, word store 2, sub-word store 3 (RMW). req_ready only in IDLE.
module mem_access_unit #(
  parameter int ADDR_WIDTH      = 32,
  parameter bit TRAP_MISALIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_fault,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_adr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t                  state;
  logic                    wr_q;
  logic                    signed_q;
  logic                    fault_q;
  logic [1:0]              size_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic [31:0]             buf_q;

  logic                    misaligned;
  logic                    fault_in;
  logic [ADDR_WIDTH-1:0]   addr_in;

  always_comb begin
    misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                 ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    addr_in    = req_addr;
    // Without trapping, misaligned addresses are silently snapped to alignment.
    if (!TRAP_MISALIGNED) begin
      if (req_size == 2'b01) addr_in[0]   = 1'b0;
      if (req_size == 2'b10) addr_in[1:0] = 2'b00;
    end
    fault_in = (req_size == 2'b11) || (TRAP_MISALIGNED && misaligned);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wr_q     <= 1'b0;
      signed_q <= 1'b0;
      fault_q  <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      buf_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q     <= req_write;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= addr_in;
            wdata_q  <= req_wdata;
            fault_q  <= fault_in;
            if (fault_in)                 state <= RESP;
            else if (!req_write)          state <= RD;
            else if (req_size == 2'b10)   state <= WR;
            else                          state <= RD;
          end
        end
        RD: begin
          buf_q <= mem_rdata;
          state <= wr_q ? WR : RESP;
        end
        WR:      state <= RESP;
        default: state <= IDLE;
      endcase
    end
  end

  logic [31:0] merged;
  logic [31:0] extended;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    merged = buf_q;
    case (size_q)
      2'b00: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01: begin
        if (addr_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    lane_b = buf_q[{addr_q[1:0], 3'b000} +: 8];
    lane_h = addr_q[1] ? buf_q[31:16] : buf_q[15:0];
    case (size_q)
      2'b00:   extended = {{24{signed_q & lane_b[7]}}, lane_b};
      2'b01:   extended = {{16{signed_q & lane_h[15]}}, lane_h};
      default: extended = buf_q;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_read   = (state == RD);
  assign mem_write  = (state == WR);
  assign mem_adr    = (state == RD || state == WR) ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign mem_wdata  = (state == WR) ? merged : 32'h0;
  assign resp_rdata = (state == RESP && !wr_q && !fault_q) ? extended : 32'h0;
  assign resp_fault = (state == RESP) && fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 64-word behavioural memory.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_adr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:63];
  logic        poke_vld;
  logic [5:0]  poke_idx;
  logic [31:0] poke_dat;

  int          n_cmp = 0;
  int          n_err = 0;
  int          lat, rd_at, wr_at;
  logic        got_valid, got_fault;
  logic [31:0] got_rdata;

  mem_access_unit #(.ADDR_WIDTH(32), .TRAP_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .mem_read(mem_read), .mem_write(mem_write),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_adr[7:2]];

  always @(posedge clk) begin
    if (mem_write)     mem[mem_adr[7:2]] <= mem_wdata;
    else if (poke_vld) mem[poke_idx]     <= poke_dat;
  end

  task automatic poke(input logic [5:0] idx, input logic [31:0] dat);
    @(negedge clk); poke_vld = 1'b1; poke_idx = idx; poke_dat = dat;
    @(posedge clk); #1 poke_vld = 1'b0;
  endtask

  // Issue one request and record latency (edges after accept) and response.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = d;
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0; rd_at = 0; wr_at = 0; got_valid = 1'b0; got_fault = 1'b0; got_rdata = 32'hx;
    for (int c = 1; c <= 10 && !got_valid; c++) begin
      @(negedge clk);
      if (mem_read && rd_at == 0)  rd_at = c;
      if (mem_write && wr_at == 0) wr_at = c;
      if (resp_valid) begin
        got_valid = 1'b1; lat = c; got_rdata = resp_rdata; got_fault = resp_fault;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_cmp++; if ({resp_valid, resp_fault, mem_read, mem_write} !== 4'b0) begin n_err++;
      $display("FAIL reset_strobes: got %b want 0000", {resp_valid, resp_fault, mem_read, mem_write}); end
    n_cmp++; if ({mem_adr, mem_wdata, resp_rdata} !== 96'h0) begin n_err++;
      $display("FAIL reset_buses: got %h want 0", {mem_adr, mem_wdata, resp_rdata}); end
    rst = 1'b0;
  endtask

  task automatic test_word;
    issue(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL wst_latency: got %0d want 2", lat); end
    n_cmp++; if (wr_at !== 1) begin n_err++; $display("FAIL wst_wr_cycle: got %0d want 1", wr_at); end
    n_cmp++; if (rd_at !== 0) begin n_err++; $display("FAIL wst_no_read: got %0d want 0", rd_at); end
    n_cmp++; if (mem[16] !== 32'hDEADBEEF) begin n_err++; $display("FAIL wst_mem: got %h want deadbeef", mem[16]); end
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL wld_latency: got %0d want 2", lat); end
    n_cmp++; if ({got_fault, got_rdata} !== {1'b0, 32'hDEADBEEF}) begin n_err++;
      $display("FAIL wld_data: got %b/%h want 0/deadbeef", got_fault, got_rdata); end
  endtask

  task automatic test_byte_store;
    poke(6'd16, 32'h11223344);
    issue(1'b1, 2'b00, 1'b0, 32'h41, 32'h000000A5);
    n_cmp++; if ({rd_at, wr_at, lat} !== {32'd1, 32'd2, 32'd3}) begin n_err++;
      $display("FAIL bst_timing: got rd%0d wr%0d resp%0d want rd1 wr2 resp3", rd_at, wr_at, lat); end
    n_cmp++; if (mem[16] !== 32'h1122A544) begin n_err++; $display("FAIL bst_mem: got %h want 1122a544", mem[16]); end
    n_cmp++; if (got_rdata !== 32'h0) begin n_err++; $display("FAIL bst_rdata: got %h want 0", got_rdata); end
    issue(1'b1, 2'b01, 1'b0, 32'h42, 32'h0000BEEF);
    n_cmp++; if (mem[16] !== 32'hBEEFA544) begin n_err++; $display("FAIL hst_mem: got %h want beefa544", mem[16]); end
  endtask

  task automatic test_extend;
    poke(6'd16, 32'h80F00000);
    issue(1'b0, 2'b00, 1'b1, 32'h42, 32'h0);
    n_cmp++; if (got_rdata !== 32'hFFFFFFF0) begin n_err++; $display("FAIL lb_signed: got %h want fffffff0", got_rdata); end
    issue(1'b0, 2'b00, 1'b0, 32'h42, 32'h0);
    n_cmp++; if (got_rdata !== 32'h000000F0) begin n_err++; $display("FAIL lb_unsigned: got %h want 000000f0", got_rdata); end
    issue(1'b0, 2'b01, 1'b1, 32'h42, 32'h0);
    n_cmp++; if (got_rdata !== 32'hFFFF80F0) begin n_err++; $display("FAIL lh_signed: got %h want ffff80f0", got_rdata); end
    issue(1'b0, 2'b01, 1'b0, 32'h42, 32'h0);
    n_cmp++; if (got_rdata !== 32'h000080F0) begin n_err++; $display("FAIL lh_unsigned: got %h want 000080f0", got_rdata); end
    issue(1'b0, 2'b00, 1'b1, 32'h40, 32'h0);
    n_cmp++; if (got_rdata !== 32'h00000000) begin n_err++; $display("FAIL lb_lane0: got %h want 0", got_rdata); end
  endtask

  task automatic test_fault;
    issue(1'b0, 2'b01, 1'b1, 32'h43, 32'h0);
    n_cmp++; if ({lat, got_fault, got_rdata} !== {32'd1, 1'b1, 32'h0}) begin n_err++;
      $display("FAIL flt_half: got lat%0d f%b %h want lat1 f1 0", lat, got_fault, got_rdata); end
    n_cmp++; if ({rd_at, wr_at} !== 64'h0) begin n_err++; $display("FAIL flt_half_mem: got rd%0d wr%0d want none", rd_at, wr_at); end
    issue(1'b1, 2'b10, 1'b0, 32'h42, 32'h12345678);
    n_cmp++; if ({lat, got_fault, rd_at, wr_at} !== {32'd1, 1'b1, 32'd0, 32'd0}) begin n_err++;
      $display("FAIL flt_word: got lat%0d f%b rd%0d wr%0d want lat1 f1 none", lat, got_fault, rd_at, wr_at); end
    n_cmp++; if (mem[16] !== 32'h80F00000) begin n_err++; $display("FAIL flt_mem: got %h want 80f00000", mem[16]); end
    issue(1'b0, 2'b11, 1'b0, 32'h40, 32'h0);
    n_cmp++; if ({lat, got_fault} !== {32'd1, 1'b1}) begin n_err++;
      $display("FAIL flt_size: got lat%0d f%b want lat1 f1", lat, got_fault); end
  endtask

  task automatic test_reset_mid_rmw;
    int seen;
    poke(6'd17, 32'h55667788);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_signed = 1'b0;
    req_addr = 32'h44; req_wdata = 32'h0000BEEF;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (mem_write !== 1'b1) begin n_err++; $display("FAIL rmw_in_wr: got %b want 1", mem_write); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if ({mem_write, mem_read, req_ready} !== 3'b001) begin n_err++;
      $display("FAIL rst_async: got wr%b rd%b rdy%b want 0 0 1", mem_write, mem_read, req_ready); end
    n_cmp++; if ({mem_adr, mem_wdata} !== 64'h0) begin n_err++; $display("FAIL rst_bus: got %h want 0", {mem_adr, mem_wdata}); end
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (4) begin @(negedge clk); if (resp_valid) seen++; end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rst_no_resp: got %0d want 0", seen); end
    n_cmp++; if (mem[17] !== 32'h55667788) begin n_err++; $display("FAIL rst_mem: got %h want 55667788", mem[17]); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] got[$];
    logic [31:0] want [4];
    want[0] = 32'h10000000; want[1] = 32'h10000033; want[2] = 32'h10000066; want[3] = 32'h10000099;
    for (int i = 0; i < 10; i++) poke(6'(32 + i), 32'h10000000 + 32'(i * 17));
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (resp_valid) got.push_back(resp_rdata);
      if (c < 10) begin
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h80 + 32'(c * 4); req_wdata = 32'h0;
      end else req_valid = 1'b0;
    end
    n_cmp++; if (got.size() !== 4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", got.size()); end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      n_cmp++; if (got[k] !== want[k]) begin n_err++; $display("FAIL b2b_resp%0d: got %h want %h", k, got[k], want[k]); end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; poke_vld = 1'b0; poke_idx = 6'd0; poke_dat = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    test_reset;
    test_word;
    test_byte_store;
    test_extend;
    test_fault;
    test_reset_mid_rmw;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory port: converts MEM-stage load/store requests into mem_read/mem_write/adr/write_data cycles on the word-wide data memory.
- Supports byte, halfword and word accesses, with sign/zero extension on loads.
- Sub-word stores are done as read-modify-write on the word-only memory.
- Sits between the pipeline MEM stage and the data memory; the pipeline stalls while req_ready=0.

Parameters:
ADDR_WIDTH, 32, width of byte address on both sides
TRAP_MISALIGNED, 1, 1: misaligned request faults with no memory access; 0: low address bits are forced to alignment and the access proceeds

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  request strobe, sampled only when req_ready=1
req_ready  output  1  high in IDLE only
req_write  input  1  1=store, 0=load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal (treated as fault)
req_signed  input  1  loads: 1 sign-extend, 0 zero-extend
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data; 0 for stores and faults
resp_fault  output  1  qualifies resp_valid; misaligned or illegal size
mem_read  output  1  memory read enable
mem_write  output  1  memory write enable (memory writes at posedge clk)
mem_adr  output  ADDR_WIDTH  word-aligned address {addr[ADDR_WIDTH-1:2],2'b00}
mem_wdata  output  32  merged write word
mem_rdata  input  32  combinational read data from memory

Behaviour:
- Byte order is little-endian within a word: lane k = bits [8k+7:8k], selected by addr[1:0]. Half lane = addr[1].
- FSM states: IDLE, RD, WR, RESP. All state, latched request fields, and the data buffer are registered.
- mem_read, mem_write, req_ready and resp_valid are decoded from the state register only (Moore).
- IDLE:
  - req_ready=1.
  - When req_valid=1, latch write, size, signed, addr and wdata.
  - Misaligned or illegal with TRAP_MISALIGNED=1 -> RESP with fault flag set.
  - Otherwise: load -> RD; word store -> WR; byte/half store -> RD.
- RD:
  - mem_read=1, mem_adr=aligned latched address.
  - At the clock edge, mem_rdata is captured into buf.
  - Load -> RESP; sub-word store -> WR.
- WR:
  - mem_write=1, mem_adr=aligned address.
  - mem_wdata = latched wdata for a word store.
  - For a sub-word store, mem_wdata = buf with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0].
  - Next state RESP.
- RESP:
  - resp_valid=1.
  - For loads, resp_rdata = extracted lane, sign- or zero-extended to 32 bits. For stores and faults, resp_rdata = 0.
  - resp_fault = latched fault flag.
  - Next state IDLE.
- Outside RD/WR: mem_read=0, mem_write=0, mem_adr=0, mem_wdata=0.
- Latency from the accepting edge to the cycle in which resp_valid=1:
  - load: 2
  - word store: 2
  - sub-word store: 3
  - fault: 1
- Back-to-back: the next request can be accepted in the cycle after RESP (one IDLE cycle minimum).
- req_valid while req_ready=0 is ignored and not queued.
- Store-after-store to the same word is coherent: the RMW read occurs after the prior WR edge.
- Reset (asynchronous, at any time, including mid-RMW):
  - State goes to IDLE; all outputs go to 0 except req_ready=1.
  - A write in WR is dropped if rst rises before the clock edge.
  - No resp_valid is produced for an aborted request.
- TRAP_MISALIGNED=0: addr[0] is cleared for half and addr[1:0] for word. Size 11 still faults.

Test Plan:
- Word store then load, addr 0x40, data 0xDEADBEEF -> WR cycle 1 after accept, mem[16]=0xDEADBEEF; load resp_valid 2 cycles after accept, rdata 0xDEADBEEF, fault 0.
- Byte store 0xA5 to addr 0x41 with mem[16]=0x11223344 -> RD then WR; mem[16]=0x1122A544; resp at +3.
- Byte load from 0x42 of word 0x80F00000 -> signed returns 0xFFFFFFF0, unsigned returns 0x000000F0; half load from 0x42 signed returns 0xFFFF80F0.
- Half load at 0x43 and word store at 0x42 with TRAP_MISALIGNED=1 -> resp_valid at +1 with resp_fault=1, rdata 0, mem_read and mem_write never asserted, memory unchanged.
- Assert rst asynchronously during the WR state of a half store -> mem_write drops immediately, memory word unchanged, no resp_valid, req_ready=1 after reset.
- Hold req_valid=1 with different requests for 10 cycles -> only requests sampled in IDLE execute; responses are strictly one per accepted request, in order.
